// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable integer clock divider with glitch-free reconfiguration
// Optional PROG_CLK_DIV_SYNC_EN adds a sync input that forces an immediate period restart.
module prog_clock_divider #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int WIDTH        = 32,
  parameter int DEFAULT_DIV  = 50_000,
  parameter int DEFAULT_HIGH = 25_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  // Marks an unusable parameter set in the elaborated hierarchy.
  generate
    if (CLK_FREQ <= 0 || DEFAULT_DIV < 2 || DEFAULT_HIGH < 1 || DEFAULT_HIGH >= DEFAULT_DIV) begin : g_bad_params
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] high_act_q, high_act_d;
  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic [WIDTH-1:0] high_sh_q, high_sh_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_cl;
  logic [WIDTH-1:0] high_cl;
  logic             sync_hit;
  logic             wrap;
  logic             apply;

  always_comb begin
    div_cl = (div_in < TWO) ? TWO : div_in;
    if (high_in == '0) begin
      high_cl = ONE;
    end else if (high_in >= div_cl) begin
      high_cl = div_cl - ONE;
    end else begin
      high_cl = high_in;
    end
  end

  always_comb begin
`ifdef PROG_CLK_DIV_SYNC_EN
    sync_hit = en & sync;
`else
    sync_hit = 1'b0;
`endif
    wrap  = sync_hit | (cnt_q == div_act_q - ONE);
    apply = en & wrap & pending_q;
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    high_act_d = high_act_q;
    div_sh_d   = div_sh_q;
    high_sh_d  = high_sh_q;
    pending_d  = pending_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
      if (apply) begin
        div_act_d  = div_sh_q;
        high_act_d = high_sh_q;
        pending_d  = 1'b0;
      end
      // High time of the period that cnt_d belongs to, so a new config takes effect on cycle 0.
      clk_out_d = (cnt_d < high_act_d);
      tick_d    = (cnt_d == '0);
    end

    // A capture on the applying edge keeps pending set; the fresh values wait for the next wrap.
    if (load) begin
      div_sh_d  = div_cl;
      high_sh_d = high_cl;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= DEF_DIV - ONE;
      div_act_q  <= DEF_DIV;
      high_act_q <= DEF_HIGH;
      div_sh_q   <= DEF_DIV;
      high_sh_q  <= DEF_HIGH;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      high_act_q <= high_act_d;
      div_sh_q   <= div_sh_d;
      high_sh_q  <= high_sh_d;
      pending_q  <= pending_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - scoreboard bench for prog_clock_divider with hand-written waveforms
module tb_prog_clock_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] div_in;
  logic [15:0] high_in;
`ifdef PROG_CLK_DIV_SYNC_EN
  logic        sync;
`endif
  logic        clk_out;
  logic        tick;
  logic        pending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic  c;
    logic  t;
    logic  p;
    string nm;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  prog_clock_divider #(
    .CLK_FREQ    (50_000_000),
    .WIDTH       (16),
    .DEFAULT_DIV (10),
    .DEFAULT_HIGH(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .div_in (div_in),
    .high_in(high_in),
`ifdef PROG_CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  task automatic check_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", nm, got, want);
    end
  endtask

  // Monitor: compares the outputs produced by each edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_bit({e.nm, " clk_out"}, clk_out, e.c);
      check_bit({e.nm, " tick"}, tick, e.t);
      check_bit({e.nm, " pending"}, pending, e.p);
    end
  end

  task automatic cyc(input logic e, input logic l, input int d, input int h, input logic s,
                     input logic c, input logic t, input logic p, input string nm);
    exp_t x;
    @(negedge clk);
    en      = e;
    load    = l;
    div_in  = 16'(d);
    high_in = 16'(h);
`ifdef PROG_CLK_DIV_SYNC_EN
    sync    = s;
`else
    if (s) $display("note: sync requested without sync build");
`endif
    x.c  = c;
    x.t  = t;
    x.p  = p;
    x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic run(input string nm, input logic e, input string cp, input string tp, input string pp);
    for (int i = 0; i < cp.len(); i++) begin
      cyc(e, 1'b0, 0, 0, 1'b0, cp[i] == "1", tp[i] == "1", pp[i] == "1", $sformatf("%s[%0d]", nm, i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    div_in  = '0;
    high_in = '0;
`ifdef PROG_CLK_DIV_SYNC_EN
    sync    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_bit("reset clk_out", clk_out, 1'b0);
    check_bit("reset tick", tick, 1'b0);
    check_bit("reset pending", pending, 1'b0);
    rst = 1'b0;

    // Default 10/5 waveform, first tick on the first enabled edge.
    run("default", 1'b1, "11111000001111100000", "10000000001000000000", "00000000000000000000");

    // Mid-period load of div 4 / high 1: current period finishes first.
    run("pre_load", 1'b1, "111", "100", "000");
    cyc(1'b1, 1'b1, 4, 1, 1'b0, 1'b1, 1'b0, 1'b1, "load4");
    run("load4_wait", 1'b1, "100000", "000000", "111111");
    run("div4", 1'b1, "10001000", "10001000", "00000000");

    // Clamp div 0 / high 0 to period 2, high 1 (load lands on a wrap edge with nothing pending).
    cyc(1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, "load0");
    run("load0_wait", 1'b1, "000", "000", "111");
    run("div2", 1'b1, "1010", "1010", "0000");

    // Clamp high 9 against div 6 to high 5.
    cyc(1'b1, 1'b1, 6, 9, 1'b0, 1'b1, 1'b1, 1'b1, "load6");
    run("load6_wait", 1'b1, "0", "0", "1");
    run("div6", 1'b1, "111110111110", "100000100000", "000000000000");

    // Freeze for 7 cycles in the high phase.
    run("pre_freeze", 1'b1, "111", "100", "000");
    run("freeze", 1'b0, "1111111", "0000000", "0000000");
    run("resume", 1'b1, "1101", "0001", "0000");

    // Two loads before the wrap, then a load on the wrap edge.
    cyc(1'b1, 1'b1, 8, 4, 1'b0, 1'b1, 1'b0, 1'b1, "load8");
    cyc(1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b0, 1'b1, "load3");
    run("load3_wait", 1'b1, "110", "000", "111");
    cyc(1'b1, 1'b1, 5, 2, 1'b0, 1'b1, 1'b1, 1'b1, "load5_on_wrap");
    run("div3", 1'b1, "00", "00", "11");
    run("div5", 1'b1, "110001", "100001", "000000");

    // Asynchronous reset in mid-period with a config pending.
    cyc(1'b1, 1'b1, 7, 3, 1'b0, 1'b1, 1'b0, 1'b1, "load7");
    @(negedge clk);
    en = 1'b0;
    load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_rst clk_out", clk_out, 1'b0);
    check_bit("async_rst tick", tick, 1'b0);
    check_bit("async_rst pending", pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef PROG_CLK_DIV_SYNC_EN
    run("post_rst", 1'b1, "1111100", "1000000", "0000000");
    cyc(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, "sync");
    cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, "sync_disabled");
    run("post_sync", 1'b1, "1111000001", "0000000001", "0000000000");
`else
    run("post_rst", 1'b1, "11111000001", "10000000001", "00000000000");
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
